// File: rtl/up_control.sv
`default_nettype none
// ============================================================================
//  Module      : up_control
//  Description : Multi-cycle control unit for up_datapath. Fetches an opcode
//                byte (and an optional operand byte) from memory, then drives
//                every datapath control strobe for one execute cycle.
//                Sequence: FETCH -> DECODE -> [OPERAND -> EXEC] -> FETCH,
//                with HALT as a terminal state left only through rst.
//  Ports       : clk, rst            clock / synchronous active-high reset
//                ir[3:0], zero       opcode and ALU zero flag from datapath
//                data_in[7:0]        memory read data (operand byte)
//                mem_ready           memory data valid this cycle
//                mem_rd, ir_we       memory read request / IR load strobe
//                pc_we, pc_ld        PC write strobe / 1 = load jump target
//                a_sel_in_a/b, a_op  ALU input muxes and operation
//                rb_sel_out_a/b      register-bank read selects
//                rb_sel_in           register-bank write select
//                rb_sel_data_in      write source: 1 = data_in, 0 = ALU
//                rb_we               register-bank write strobe
//                sp_we, sp_dn        SP update strobe / 1 = decrement
//  Revision    : 1.0 - initial release
// ============================================================================
module up_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ir,
    input  logic       zero,
    input  logic [7:0] data_in,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_ld,
    output logic       a_sel_in_a,
    output logic       a_sel_in_b,
    output logic [3:0] a_op,
    output logic [1:0] rb_sel_out_a,
    output logic [1:0] rb_sel_out_b,
    output logic [1:0] rb_sel_in,
    output logic       rb_sel_data_in,
    output logic       rb_we,
    output logic       sp_we,
    output logic       sp_dn
);

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_AND  = 4'h3;
    localparam logic [3:0] c_OP_OR   = 4'h4;
    localparam logic [3:0] c_OP_XOR  = 4'h5;
    localparam logic [3:0] c_OP_NOT  = 4'h6;
    localparam logic [3:0] c_OP_SHL  = 4'h7;
    localparam logic [3:0] c_OP_SHR  = 4'h8;
    localparam logic [3:0] c_OP_MOV  = 4'h9;
    localparam logic [3:0] c_OP_LDI  = 4'hA;
    localparam logic [3:0] c_OP_PUSH = 4'hB;
    localparam logic [3:0] c_OP_POP  = 4'hC;
    localparam logic [3:0] c_OP_JMP  = 4'hD;
    localparam logic [3:0] c_OP_JZ   = 4'hE;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_OPERAND = 3'd2,
        S_EXEC    = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_opnd;

    // Operand byte fields used by EXEC.
    logic [1:0] w_dst;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;

    assign w_dst   = r_opnd[1:0];
    assign w_src_a = r_opnd[3:2];
    assign w_src_b = r_opnd[5:4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_opnd  <= 8'h00;
        end else begin
            r_state <= w_next;
            if ((r_state == S_OPERAND) && mem_ready) begin
                r_opnd <= data_in;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        mem_rd         = 1'b0;
        ir_we          = 1'b0;
        pc_we          = 1'b0;
        pc_ld          = 1'b0;
        a_sel_in_a     = 1'b0;
        a_sel_in_b     = 1'b0;
        a_op           = 4'h0;
        rb_sel_out_a   = 2'd0;
        rb_sel_out_b   = 2'd0;
        rb_sel_in      = 2'd0;
        rb_sel_data_in = 1'b0;
        rb_we          = 1'b0;
        sp_we          = 1'b0;
        sp_dn          = 1'b0;

        // Reset masks every output combinationally so an instruction caught
        // mid-execute produces no side effect in the reset cycle.
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_we  = 1'b1;
                        pc_we  = 1'b1;
                        w_next = S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (ir == c_OP_NOP) begin
                        w_next = S_FETCH;
                    end else if (ir == c_OP_HALT) begin
                        w_next = S_HALT;
                    end else begin
                        w_next = S_OPERAND;
                    end
                end

                S_OPERAND: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        pc_we  = 1'b1;
                        w_next = S_EXEC;
                    end
                end

                S_EXEC: begin
                    w_next = S_FETCH;
                    case (ir)
                        c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
                        c_OP_XOR, c_OP_NOT, c_OP_SHL, c_OP_SHR: begin
                            a_op         = ir;
                            rb_we        = 1'b1;
                            rb_sel_in    = w_dst;
                            rb_sel_out_a = w_src_a;
                            rb_sel_out_b = w_src_b;
                        end
                        c_OP_MOV: begin
                            a_op         = c_OP_MOV;   // ALU pass-through of A
                            rb_we        = 1'b1;
                            rb_sel_in    = w_dst;
                            rb_sel_out_a = w_src_a;
                        end
                        c_OP_LDI: begin
                            rb_sel_data_in = 1'b1;
                            rb_we          = 1'b1;
                            rb_sel_in      = w_dst;
                        end
                        c_OP_PUSH: begin
                            sp_we        = 1'b1;
                            sp_dn        = 1'b1;
                            rb_sel_out_a = w_src_a;
                        end
                        c_OP_POP: begin
                            sp_we     = 1'b1;
                            rb_we     = 1'b1;
                            rb_sel_in = w_dst;
                        end
                        c_OP_JMP: begin
                            pc_we = 1'b1;
                            pc_ld = 1'b1;
                        end
                        c_OP_JZ: begin
                            pc_we = zero;
                            pc_ld = zero;
                        end
                        default: begin
                            // NOP/HALT never reach EXEC.
                        end
                    endcase
                end

                S_HALT: begin
                    w_next = S_HALT;
                end

                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
